// File: rtl/stepper_motor_driver.sv
// Single-motor stepper phase driver: command handshake, wave/full/half sequencing, signed position.
// Optional acceleration ramp enabled by defining STEPPER_RAMP_EN.
module stepper_motor_driver #(
  parameter int STEPS_W    = 16,
  parameter int PERIOD_W   = 20,
  parameter int POS_W      = 24,
  parameter int RAMP_START = 50000,
  parameter int RAMP_DEC   = 64
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [STEPS_W-1:0]  cmd_steps,
  input  logic                cmd_dir,
  input  logic [1:0]          cmd_mode,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  output logic [3:0]          coil_out,
  output logic                step_pulse,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [POS_W-1:0]    position
);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic [2:0]          idx, snap;
  logic                energised, half, dir;
  logic [STEPS_W-1:0]  rem;
  logic [PERIOD_W-1:0] cnt, per, cur_per, p_req;
  logic                done_pend;
  logic                accept, step, last;
  logic [1:0]          stride;
  logic [POS_W-1:0]    pos_delta;

  function automatic logic [3:0] pattern(input logic [2:0] i);
    case (i)
      3'd0: pattern = 4'b1000;
      3'd1: pattern = 4'b1100;
      3'd2: pattern = 4'b0100;
      3'd3: pattern = 4'b0110;
      3'd4: pattern = 4'b0010;
      3'd5: pattern = 4'b0011;
      3'd6: pattern = 4'b0001;
      default: pattern = 4'b1001;
    endcase
  endfunction

  always_comb begin
    p_req     = (cmd_period == '0) ? PERIOD_W'(1) : cmd_period;
    // wave uses the single-coil (even) entries, full the two-coil (odd) ones
    case (cmd_mode)
      2'b00:   snap = idx & 3'b110;
      2'b10:   snap = idx;
      default: snap = idx | 3'b001;
    endcase
    stride    = half ? 2'd1 : 2'd2;
    pos_delta = dir ? {{(POS_W-2){1'b0}}, stride} : -{{(POS_W-2){1'b0}}, stride};
    coil_out  = energised ? pattern(idx) : 4'b0000;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        accept    = cmd_valid;
        if (cmd_valid && cmd_steps != '0) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        // abort beats a coincident period expiry
        step = !abort && (cnt == cur_per - 1'b1);
        last = step && (rem == STEPS_W'(1));
        if (abort || last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state      <= IDLE;
      idx        <= '0;
      energised  <= 1'b0;
      half       <= 1'b0;
      dir        <= 1'b0;
      rem        <= '0;
      cnt        <= '0;
      per        <= '0;
      position   <= '0;
      step_pulse <= 1'b0;
      done_pend  <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state      <= state_nxt;
      step_pulse <= step;
      done_pend  <= last;
      done       <= done_pend || (accept && cmd_steps == '0);
      aborted    <= (state == RUN) && abort;
      if (accept) begin
        idx       <= snap;
        energised <= 1'b1;
        half      <= (cmd_mode == 2'b10);
        dir       <= cmd_dir;
        rem       <= cmd_steps;
        cnt       <= '0;
        per       <= p_req;
      end else if (state == RUN) begin
        if (step) begin
          idx      <= dir ? idx + {1'b0, stride} : idx - {1'b0, stride};
          rem      <= rem - 1'b1;
          cnt      <= '0;
          position <= position + pos_delta;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

`ifdef STEPPER_RAMP_EN
  localparam logic [PERIOD_W:0] RS = (PERIOD_W+1)'(RAMP_START);
  localparam logic [PERIOD_W:0] RD = (PERIOD_W+1)'(RAMP_DEC);
  logic [STEPS_W-1:0] acc;
  logic [PERIOD_W:0]  up, dn_lim;

  always_comb begin
    up     = {1'b0, cur_per} + RD;
    dn_lim = {1'b0, per} + RD;
  end

  // trapezoid: shorten toward cmd_period, then mirror the accel step count on the way down
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      cur_per <= '0;
      acc     <= '0;
    end else if (accept) begin
      cur_per <= ({1'b0, p_req} >= RS) ? p_req : RS[PERIOD_W-1:0];
      acc     <= '0;
    end else if (step) begin
      if (rem - 1'b1 <= acc) begin
        if ({1'b0, cur_per} < RS) cur_per <= (up > RS) ? RS[PERIOD_W-1:0] : up[PERIOD_W-1:0];
      end else if (cur_per > per) begin
        cur_per <= ({1'b0, cur_per} > dn_lim) ? cur_per - RD[PERIOD_W-1:0] : per;
        acc     <= acc + 1'b1;
      end
    end
  end
`else
  assign cur_per = per;
`endif

endmodule

// File: tb/tb_stepper_motor_driver.sv
// Randomized bench for stepper_motor_driver; expected step times, coil pattern and position
// are derived per command from k*P step arithmetic and a pattern table.
module tb_stepper_motor_driver;
  localparam int STEPS_W = 8, PERIOD_W = 8, POS_W = 8;

  logic                clk_clk = 1'b0, reset_reset = 1'b0;
  logic                cmd_valid = 1'b0, cmd_ready, cmd_dir = 1'b0, abort = 1'b0;
  logic [STEPS_W-1:0]  cmd_steps = '0;
  logic [1:0]          cmd_mode = '0;
  logic [PERIOD_W-1:0] cmd_period = '0;
  logic [3:0]          coil_out;
  logic                step_pulse, busy, done, aborted;
  logic [POS_W-1:0]    position;

  stepper_motor_driver #(.STEPS_W(STEPS_W), .PERIOD_W(PERIOD_W), .POS_W(POS_W)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_mode(cmd_mode), .cmd_period(cmd_period),
    .abort(abort), .coil_out(coil_out), .step_pulse(step_pulse), .busy(busy), .done(done),
    .aborted(aborted), .position(position)
  );

  always #5 clk_clk = ~clk_clk;

  logic [3:0] tbl [0:7] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
  int vectors = 0, miscompares = 0;
  int m_idx = 0, m_pos = 0;
  bit m_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_clk);
    reset_reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    @(negedge clk_clk);
    chk("rst_coil", coil_out, 0);
    chk("rst_pos", position, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_step", step_pulse, 0);
    chk("rst_done", done, 0);
    chk("rst_abt", aborted, 0);
    reset_reset = 1'b0;
    @(negedge clk_clk);
    chk("rst_done2", done, 0);
    chk("rst_abt2", aborted, 0);
    chk("rst_coil2", coil_out, 0);
    m_idx = 0; m_pos = 0; m_en = 1'b0;
  endtask

  // abort_at: abort sampled on the edge abort_at cycles after the accept edge (0 = none)
  task automatic run_cmd(input int steps, input bit dir, input logic [1:0] mode,
                         input int period, input int abort_at, input bit hold);
    int p, stride, sgn, snap, n, fin, k, e_idx, e_pos;
    bit abt, half;
    p      = (period == 0) ? 1 : period;
    half   = (mode == 2'b10);
    stride = half ? 1 : 2;
    sgn    = dir ? 1 : -1;
    snap   = (mode == 2'b00) ? (m_idx & 6) : half ? m_idx : (m_idx | 1);
    abt    = steps > 0 && abort_at > 0 && abort_at <= steps * p;
    fin    = (steps == 0) ? 0 : abt ? abort_at : steps * p;
    n      = abt ? (abort_at - 1) / p : steps;
    @(negedge clk_clk);
    chk("ready_pre", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_steps = STEPS_W'(steps); cmd_dir = dir;
    cmd_mode = mode; cmd_period = PERIOD_W'(period);
    abort = 1'($urandom_range(0, 1));
    @(negedge clk_clk);
    if (!hold) cmd_valid = 1'b0;
    else begin
      cmd_steps = STEPS_W'($urandom); cmd_dir = ~dir;
      cmd_mode = 2'($urandom); cmd_period = PERIOD_W'($urandom_range(1, 3));
    end
    for (int c = 0; c <= fin + 2; c++) begin
      k     = (c / p < n) ? c / p : n;
      e_idx = (((snap + sgn * stride * k) % 8) + 8) % 8;
      e_pos = (m_pos + sgn * stride * k) & 8'hFF;
      chk("step", step_pulse, (c > 0 && c % p == 0 && c / p <= n) ? 1 : 0);
      chk("busy", busy, (c < fin) ? 1 : 0);
      chk("ready", cmd_ready, (c < fin) ? 0 : 1);
      chk("coil", coil_out, tbl[e_idx]);
      chk("pos", position, e_pos);
      chk("done", done, ((steps == 0) ? (c == 0) : (!abt && c == fin + 1)) ? 1 : 0);
      chk("aborted", aborted, (abt && c == fin) ? 1 : 0);
      if (hold && c == fin) cmd_valid = 1'b0;
      if (c + 1 > fin) abort = 1'($urandom_range(0, 1));
      else abort = (abt && c + 1 == abort_at) ? 1'b1 : 1'b0;
      if (c < fin + 2) @(negedge clk_clk);
    end
    abort = 1'b0;
    m_idx = (((snap + sgn * stride * n) % 8) + 8) % 8;
    m_pos = (m_pos + sgn * stride * n) & 8'hFF;
    m_en  = 1'b1;
  endtask

  initial begin
    int st, pr, ab;
    do_reset();

    run_cmd(8, 1'b1, 2'b10, 4, 0, 1'b0);
    chk("t1_pos", position, 8);

    do_reset();
    run_cmd(3, 1'b0, 2'b01, 1, 0, 1'b0);
    chk("t2_pos", position, 8'hFA);
    chk("t2_coil", coil_out, 4'b0110);

    do_reset();
    run_cmd(100, 1'b1, 2'b00, 10, 255, 1'b0);
    chk("t3_pos", position, 50);
    run_cmd(10, 1'b1, 2'b00, 10, 30, 1'b0);
    chk("t3b_pos", position, 54);

    run_cmd(0, 1'b1, 2'b10, 5, 0, 1'b0);
    chk("t4_pos", position, 54);

    do_reset();
    run_cmd(127, 1'b1, 2'b01, 1, 0, 1'b0);
    chk("wrap_pre", position, 254);
    run_cmd(2, 1'b1, 2'b01, 3, 0, 1'b1);
    chk("wrap_pos", position, 2);

    for (int i = 0; i < 40; i++) begin
      st = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 20);
      pr = $urandom_range(0, 6);
      ab = 0;
      if (st > 0 && $urandom_range(0, 2) == 0)
        ab = $urandom_range(1, st * ((pr == 0) ? 1 : pr));
      run_cmd(st, 1'($urandom), 2'($urandom), pr, ab, 1'($urandom));
    end

    @(negedge clk_clk);
    cmd_valid = 1'b1; cmd_steps = 8'd50; cmd_period = 8'd3; cmd_mode = 2'b01; cmd_dir = 1'b1;
    @(negedge clk_clk);
    cmd_valid = 1'b0;
    repeat (20) @(negedge clk_clk);
    chk("mid_busy", busy, 1);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
